// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the E-stage multiply/divide unit.
//   - xlu_op code constants produced by the E-stage decoder
//   - FSM state type for md_unit
//   - is_compute_op(): ops that open a busy window
//   - latency_sel(): busy-window length for a compute op
// Optional feature macro: MD_MADD_EN (accumulate ops madd/maddu/msub/msubu).
package md_pkg;

  localparam logic [3:0] XLU_MULT  = 4'b0000;
  localparam logic [3:0] XLU_MULTU = 4'b0001;
  localparam logic [3:0] XLU_DIV   = 4'b0010;
  localparam logic [3:0] XLU_DIVU  = 4'b0011;
  localparam logic [3:0] XLU_MTHI  = 4'b0100;
  localparam logic [3:0] XLU_MTLO  = 4'b0101;
  localparam logic [3:0] XLU_MFHI  = 4'b0110;
  localparam logic [3:0] XLU_MFLO  = 4'b0111;
  localparam logic [3:0] XLU_NONE  = 4'b1000;
  localparam logic [3:0] XLU_MADD  = 4'b1001;
  localparam logic [3:0] XLU_MADDU = 4'b1010;
  localparam logic [3:0] XLU_MSUB  = 4'b1011;
  localparam logic [3:0] XLU_MSUBU = 4'b1100;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  function automatic logic is_compute_op(input logic [3:0] op);
    logic r;
    case (op)
      XLU_MULT, XLU_MULTU, XLU_DIV, XLU_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
      XLU_MADD, XLU_MADDU, XLU_MSUB, XLU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic int unsigned latency_sel(input logic [3:0] op,
                                              input int unsigned mult_cycles,
                                              input int unsigned div_cycles);
    return (op == XLU_DIV || op == XLU_DIVU) ? div_cycles : mult_cycles;
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational HI/LO result generator.
// Ports:
//   i_a, i_b     rs / rt operands
//   i_op         xlu_op code
//   i_hi, i_lo   current HI/LO (accumulate base, and pass-through value)
//   o_next_hilo  next {HI,LO} for the op ({i_hi,i_lo} for non-compute ops)
//   o_div0       div/divu with a zero divisor (result must not commit)
// Optional feature macro: MD_MADD_EN (accumulate adder/subtractor).
module md_arith
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_next_hilo,
  output logic               o_div0
);

  logic [2*WIDTH-1:0] w_sprod;
  logic [2*WIDTH-1:0] w_uprod;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_dvsr_u;
  logic [WIDTH-1:0]   w_uq, w_ur;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH-1:0]   w_sq_mag, w_sr_mag;
  logic [WIDTH-1:0]   w_sq, w_sr;

  // Operands sign-extended to 2*WIDTH so the low 2*WIDTH product bits are exact.
  assign w_sprod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) *
                   $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // A zero divisor is replaced by 1 so the divider never sees 0; the result
  // is discarded via o_div0.
  assign w_b_zero = (i_b == '0);
  assign w_dvsr_u = w_b_zero ? WIDTH'(1) : i_b;
  assign w_uq     = i_a / w_dvsr_u;
  assign w_ur     = i_a % w_dvsr_u;

  // Signed divide on magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. MIN/-1 falls out naturally as lo=MIN, hi=0.
  assign w_a_neg  = i_a[WIDTH-1];
  assign w_b_neg  = i_b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? -i_a : i_a;
  assign w_mag_b  = w_b_zero ? WIDTH'(1) : (w_b_neg ? -i_b : i_b);
  assign w_sq_mag = w_mag_a / w_mag_b;
  assign w_sr_mag = w_mag_a % w_mag_b;
  assign w_sq     = (w_a_neg ^ w_b_neg) ? -w_sq_mag : w_sq_mag;
  assign w_sr     = w_a_neg ? -w_sr_mag : w_sr_mag;

  assign o_div0 = w_b_zero && (i_op == XLU_DIV || i_op == XLU_DIVU);

  always_comb begin
    o_next_hilo = {i_hi, i_lo};
    case (i_op)
      XLU_MULT:  o_next_hilo = w_sprod;
      XLU_MULTU: o_next_hilo = w_uprod;
      XLU_DIV:   if (!w_b_zero) o_next_hilo = {w_sr, w_sq};
      XLU_DIVU:  if (!w_b_zero) o_next_hilo = {w_ur, w_uq};
`ifdef MD_MADD_EN
      XLU_MADD:  o_next_hilo = {i_hi, i_lo} + w_sprod;
      XLU_MADDU: o_next_hilo = {i_hi, i_lo} + w_uprod;
      XLU_MSUB:  o_next_hilo = {i_hi, i_lo} - w_sprod;
      XLU_MSUBU: o_next_hilo = {i_hi, i_lo} - w_uprod;
`endif
      default:   o_next_hilo = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multi-cycle multiply/divide unit holding HI/LO.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        valid instruction carrying xlu_op this cycle
//   xlu_op       operation code (see md_pkg)
//   a, b         rs / rt operands
//   flush        cancel the in-flight operation
//   busy         busy window of an accepted compute op
//   hi, lo       architectural HI / LO
//   rdata        hi for mfhi, lo for mflo, else 0 (combinational)
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu accepted).
// The result is computed at acceptance into a pending register; the busy
// window only models latency before it is committed to HI/LO.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       xlu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  md_state_e          r_state;
  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_pend;
  logic               r_pend_div0;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic [2*WIDTH-1:0] w_next_hilo;
  logic               w_div0;
  logic               w_accept;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .i_a         (a),
    .i_b         (b),
    .i_op        (xlu_op),
    .i_hi        (r_hi),
    .i_lo        (r_lo),
    .o_next_hilo (w_next_hilo),
    .o_div0      (w_div0)
  );

  assign w_accept = start && !r_busy && !flush && is_compute_op(xlu_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_pend      <= '0;
      r_pend_div0 <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pend      <= w_next_hilo;
            r_pend_div0 <= w_div0;
            r_cnt       <= CW'(latency_sel(xlu_op, MULT_CYCLES, DIV_CYCLES));
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
          end else if (start && xlu_op == XLU_MTHI) begin
            r_hi <= a;
          end else if (start && xlu_op == XLU_MTLO) begin
            r_lo <= a;
          end
        end
        ST_RUN: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(1)) begin
            if (!r_pend_div0) begin
              r_hi <= r_pend[2*WIDTH-1:WIDTH];
              r_lo <= r_pend[WIDTH-1:0];
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    rdata = '0;
    if (xlu_op == XLU_MFHI)      rdata = r_hi;
    else if (xlu_op == XLU_MFLO) rdata = r_lo;
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table, hand sequences and randomized ops for md_unit.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush, busy;
  logic [3:0]  xlu_op;
  logic [31:0] a, b, hi, lo, rdata;

  int checks = 0;
  int errors = 0;
  bit [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .xlu_op(xlu_op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, eh, el;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [3:0] op, input bit [31:0] av, input bit [31:0] bv,
                       input bit [31:0] mh, input bit [31:0] ml,
                       output bit [31:0] eh, output bit [31:0] el, output int lat);
    longint sa, sb, sp, q, r;
    bit [63:0] up, acc;
    sa = $signed(av);
    sb = $signed(bv);
    sp = sa * sb;
    up = {32'b0, av} * {32'b0, bv};
    acc = {mh, ml};
    lat = 0;
    case (op)
      4'd0: begin acc = sp; lat = 5; end
      4'd1: begin acc = up; lat = 5; end
      4'd2: begin
        lat = 10;
        if (bv != 0) begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
      end
      4'd3: begin
        lat = 10;
        if (bv != 0) acc = {av % bv, av / bv};
      end
      4'd4: acc = {av, ml};
      4'd5: acc = {mh, av};
`ifdef MD_MADD_EN
      4'd9:  begin acc = acc + sp; lat = 5; end
      4'd10: begin acc = acc + up; lat = 5; end
      4'd11: begin acc = acc - sp; lat = 5; end
      4'd12: begin acc = acc - up; lat = 5; end
`endif
      default: ;
    endcase
    eh = acc[63:32];
    el = acc[31:0];
  endtask

  // Issue one op (optionally injecting a second start at busy cycle 'at'),
  // count busy cycles, then check HI/LO and the mfhi/mflo read port.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input int at, input logic [3:0] iop,
                        input logic [31:0] ia);
    int n;
    start = 1'b1; xlu_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; xlu_op = XLU_NONE;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == at) begin start = 1'b1; xlu_op = iop; a = ia; b = ia; end
      else begin start = 1'b0; xlu_op = XLU_NONE; end
      n++;
      @(negedge clk);
    end
    start = 1'b0; xlu_op = XLU_NONE;
    check({nm, " busy_cycles"}, n, lat);
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
    xlu_op = XLU_MFHI; #1;
    check({nm, " rdata_mfhi"}, rdata, eh);
    xlu_op = XLU_MFLO; #1;
    check({nm, " rdata_mflo"}, rdata, el);
    xlu_op = XLU_NONE;
  endtask

  function automatic logic [31:0] pick(input int unsigned s);
    case (s)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit [31:0] eh, el;
    int lat;
    logic [3:0] op;
    logic [31:0] ra, rb;

    vt[0]  = '{XLU_MULT,  32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5};
    vt[1]  = '{XLU_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vt[2]  = '{XLU_DIVU,  32'h7,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
    vt[3]  = '{XLU_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFD, 0};
    vt[4]  = '{XLU_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    vt[5]  = '{XLU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vt[6]  = '{XLU_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
    vt[7]  = '{XLU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vt[8]  = '{XLU_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};
    vt[9]  = '{XLU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[10] = '{XLU_NONE,  32'h5,        32'h6,        32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    vt[11] = '{XLU_MFHI,  32'h5,        32'h6,        32'hFFFFFFFF, 32'hFFFFFFFD, 0};

    reset = 1'b1; start = 1'b0; flush = 1'b0; xlu_op = XLU_NONE; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el,
             vt[i].lat, -1, XLU_NONE, 32'h0);

    // mthi then mtlo on consecutive cycles
    start = 1'b1; xlu_op = XLU_MTHI; a = 32'h12345678;
    @(negedge clk);
    xlu_op = XLU_MTLO; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0; xlu_op = XLU_NONE;
    check("mt_consec hi", hi, 32'h12345678);
    check("mt_consec lo", lo, 32'h9ABCDEF0);

    // mthi during busy ignored; second mult during busy ignored
    run_op("mthi_busy", XLU_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5, 2, XLU_MTHI, 32'hDEAD);
    run_op("mult_busy", XLU_MULT, 32'd5, 32'd6, 32'h0, 32'd30, 5, 1, XLU_MULT, 32'd7);

    // flush on busy cycle 3
    start = 1'b1; xlu_op = XLU_MULTU; a = 32'hFFFFFFFF; b = 32'h2;
    @(negedge clk);
    start = 1'b0; xlu_op = XLU_NONE;
    check("flush busy1", {31'b0, busy}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy_after", {31'b0, busy}, 32'h0);
    repeat (6) @(negedge clk);
    check("flush busy_stays0", {31'b0, busy}, 32'h0);
    check("flush hi", hi, 32'h0);
    check("flush lo", lo, 32'd30);

    // start together with flush: nothing accepted
    start = 1'b1; flush = 1'b1; xlu_op = XLU_DIV; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; xlu_op = XLU_NONE;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy !== 1'b0) lat++;
      @(negedge clk);
    end
    check("start_flush busy_cycles", lat, 0);
    check("start_flush lo", lo, 32'd30);

    // accumulate: hi=0, lo=FFFFFFFF, madd 1*1
    run_op("set_hi", XLU_MTHI, 32'h0, 32'h0, 32'h0, 32'd30, 0, -1, XLU_NONE, 32'h0);
    run_op("set_lo", XLU_MTLO, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0, -1, XLU_NONE, 32'h0);
`ifdef MD_MADD_EN
    run_op("madd", XLU_MADD, 32'h1, 32'h1, 32'h1, 32'h0, 5, -1, XLU_NONE, 32'h0);
`else
    run_op("madd_off", XLU_MADD, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0, -1, XLU_NONE, 32'h0);
`endif

    // reset mid-operation
    start = 1'b1; xlu_op = XLU_MULT; a = 32'hFFFFFFFF; b = 32'h7;
    @(negedge clk);
    start = 1'b0; xlu_op = XLU_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid busy", {31'b0, busy}, 32'h0);
    check("rst_mid hi", hi, 32'h0);
    check("rst_mid lo", lo, 32'h0);
    m_hi = '0; m_lo = '0;

    // randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 12));
      ra = pick($urandom_range(0, 7));
      rb = pick($urandom_range(0, 7));
      model(op, ra, rb, m_hi, m_lo, eh, el, lat);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, eh, el, lat, -1, XLU_NONE, 32'h0);
      m_hi = eh; m_lo = el;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
